order_parser_fifo: RTL and testbench
====================================

ORDER_PARSER_FIFO -- requirements
Module: order_parser_fifo

Interface
REQ-001 Parameter REG_WIDTH, default 32, width of each message word; message is 9 words (9*REG_WIDTH bits).
REQ-002 Parameter NUM_SYMBOLS, default 4, number of symbol-table entries; SYM_W = max(1, clog2(NUM_SYMBOLS)).
REQ-003 Parameter FIFO_DEPTH, default 4, decoded-order buffer depth, power of two, minimum 2.
REQ-004 Parameter CNT_W, default 16, width of the error counters.
REQ-005 Port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-006 Port i_rst_n, input, 1, reset, asynchronous assert, active-low.
REQ-007 Port i_data_valid, input, 1, message present on i_msg.
REQ-008 Port o_ready, input-side accept, output, 1; a message is accepted when i_data_valid and o_ready are both high at a rising edge.
REQ-009 Port i_msg, input, 9*REG_WIDTH, word k in bits [32k+31:32k], bits [7:0] are the type byte.
REQ-010 Ports i_sym_wr_en (1), i_sym_wr_idx (SYM_W), i_sym_wr_key (64), inputs, symbol-table write.
REQ-011 Port i_book_ready, input, 1, downstream accepts the output order.
REQ-012 Port o_valid, output, 1, decoded order present on outputs.
REQ-013 Ports o_order_type (2; ADD=0, CANCEL=1, EXECUTE=2), o_trade_type (1; BUY=0, SELL=1), o_stock_symbol (SYM_W), o_order_id (64), o_price (32), o_quantity (32), o_curr_time (48), o_locate_code (16), o_tracking_number (16), outputs.
REQ-014 Ports o_err_type_cnt, o_err_sym_cnt, outputs, CNT_W each, saturating drop counters.

Function
REQ-015 Type byte 0x41 = ADD, 0x58 = CANCEL, 0x45 = EXECUTE; any other byte is an unknown type.
REQ-016 Common fields: locate = bits[23:8], tracking = bits[39:24], time = bits[87:40], order_id = bits[151:88].
REQ-017 ADD: side = (bits[159:152] != 0) ? SELL : BUY; quantity = bits[191:160]; key = bits[255:192]; price = bits[287:256].
REQ-018 CANCEL: key = bits[215:152]; price, quantity, side written as 0.
REQ-019 EXECUTE: quantity = bits[183:152]; key = bits[247:184]; price, side written as 0.
REQ-020 Symbol lookup: key compared against all valid table entries; hit returns lowest matching index.
REQ-021 Table write stores key and sets the entry valid; a lookup in the same cycle as a write uses pre-write contents.
REQ-022 Accepted message with known type and symbol hit is pushed into the FIFO at the accepting edge.
REQ-023 Accepted message with unknown type is dropped; o_err_type_cnt increments by 1, saturating at all-ones.
REQ-024 Accepted message with known type and symbol miss is dropped; o_err_sym_cnt increments by 1, saturating.
REQ-025 o_ready = FIFO not full; depends only on registered state, never on i_data_valid or i_book_ready.
REQ-026 o_valid = FIFO not empty; outputs show FIFO head; pop when o_valid and i_book_ready at an edge.
REQ-027 Latency: message accepted at edge N into an empty FIFO yields o_valid high after edge N.
REQ-028 Simultaneous push and pop with FIFO non-empty: occupancy unchanged, ordering preserved.
REQ-029 When full, o_ready low; a pop that edge does not permit a push in the same cycle.
REQ-030 Outputs held stable while o_valid high and i_book_ready low.
REQ-031 Pointers wrap modulo FIFO_DEPTH; occupancy counter of clog2(FIFO_DEPTH)+1 bits distinguishes full and empty.

Reset
REQ-032 While i_rst_n low: FIFO empty, o_valid 0, o_ready 0, counters 0, all table entries invalid, data outputs 0.
REQ-033 o_ready rises at the first rising edge after i_rst_n deasserts; reset mid-operation discards buffered orders.

Verification
REQ-034 Table idx0=0x4141504C20202020; ADD, side byte 1, qty 100, price 1500, order_id 7 -> next cycle o_valid, ADD, SELL, symbol 0, qty 100, price 1500, id 7.
REQ-035 i_book_ready held 0, push FIFO_DEPTH valid orders -> o_ready low after 4th; 5th held on bus, accepted after first pop; output order 1..5.
REQ-036 Type byte 0x51 -> nothing pushed, o_err_type_cnt 0->1; repeat 2^CNT_W+3 times -> stays at 0xFFFF.
REQ-037 Empty table, CANCEL key AMZN -> dropped, o_err_sym_cnt 1; write idx1=AMZN same cycle as second CANCEL -> still dropped; third CANCEL -> symbol 1, price 0, qty 0.
REQ-038 Continuous valid input, i_book_ready=1 -> one order per cycle, o_ready stays 1, no loss.
REQ-039 Assert i_rst_n low with 3 orders buffered -> o_valid 0 immediately, counters 0, table cleared.

Source files
------------

// File: rtl/order_parser_fifo_if.sv
// Order parser bus: message input, symbol-table write, decoded-order output
// and drop counters. The bench drives through master; the parser is the slave.
interface order_parser_fifo_if #(
   parameter int REG_WIDTH   = 32,
   parameter int NUM_SYMBOLS = 4,
   parameter int CNT_W       = 16
);
   localparam int SYM_W = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;

   // message input side
   logic                   i_data_valid;
   logic                   o_ready;
   logic [9*REG_WIDTH-1:0] i_msg;

   // symbol-table write port
   logic                   i_sym_wr_en;
   logic [SYM_W-1:0]       i_sym_wr_idx;
   logic [63:0]            i_sym_wr_key;

   // decoded-order output side
   logic                   i_book_ready;
   logic                   o_valid;
   logic [1:0]             o_order_type;
   logic                   o_trade_type;
   logic [SYM_W-1:0]       o_stock_symbol;
   logic [63:0]            o_order_id;
   logic [31:0]            o_price;
   logic [31:0]            o_quantity;
   logic [47:0]            o_curr_time;
   logic [15:0]            o_locate_code;
   logic [15:0]            o_tracking_number;

   // drop counters
   logic [CNT_W-1:0]       o_err_type_cnt;
   logic [CNT_W-1:0]       o_err_sym_cnt;

   modport master (
      output i_data_valid, i_msg, i_sym_wr_en, i_sym_wr_idx, i_sym_wr_key, i_book_ready,
      input  o_ready, o_valid, o_order_type, o_trade_type, o_stock_symbol, o_order_id,
             o_price, o_quantity, o_curr_time, o_locate_code, o_tracking_number,
             o_err_type_cnt, o_err_sym_cnt
   );

   modport slave (
      input  i_data_valid, i_msg, i_sym_wr_en, i_sym_wr_idx, i_sym_wr_key, i_book_ready,
      output o_ready, o_valid, o_order_type, o_trade_type, o_stock_symbol, o_order_id,
             o_price, o_quantity, o_curr_time, o_locate_code, o_tracking_number,
             o_err_type_cnt, o_err_sym_cnt
   );
endinterface

// File: rtl/order_parser_fifo.sv
// Order parser: decodes ADD/CANCEL/EXECUTE messages, resolves the symbol key
// against a small CAM-style table and queues good orders in a FIFO.
// Unknown types and symbol misses are dropped and counted (saturating).
module order_parser_fifo #(
   parameter int REG_WIDTH   = 32,
   parameter int NUM_SYMBOLS = 4,
   parameter int FIFO_DEPTH  = 4,
   parameter int CNT_W       = 16
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   order_parser_fifo_if.slave bus
);
   localparam int SYM_W = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   localparam logic [7:0] T_ADD = 8'h41;
   localparam logic [7:0] T_CAN = 8'h58;
   localparam logic [7:0] T_EXE = 8'h45;

   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0] ERR_ONE = CNT_W'(1);

   typedef struct packed {
      logic [1:0]       order_type;
      logic             trade_type;
      logic [SYM_W-1:0] symbol;
      logic [63:0]      order_id;
      logic [31:0]      price;
      logic [31:0]      quantity;
      logic [47:0]      curr_time;
      logic [15:0]      locate;
      logic [15:0]      tracking;
   } order_t;

   logic [7:0]             type_b;
   logic                   known;
   logic [63:0]            key;
   logic [63:0]            sym_key [NUM_SYMBOLS];
   logic [NUM_SYMBOLS-1:0] sym_vld;
   logic [NUM_SYMBOLS-1:0] match;
   logic                   hit;
   logic [SYM_W-1:0]       hit_idx;
   order_t                 push_ord;
   order_t                 mem [FIFO_DEPTH];
   order_t                 head;
   logic [PTR_W-1:0]       wr_ptr, rd_ptr;
   logic [PTR_W:0]         count;
   logic                   rdy_en, full, accept, push, pop;
   logic [CNT_W-1:0]       err_type_cnt, err_sym_cnt;

   assign type_b = bus.i_msg[7:0];

   // classify the type byte and pick out the symbol key for that layout
   always_comb begin
      known = 1'b1;
      key   = '0;
      case (type_b)
         T_ADD:   key = bus.i_msg[255:192];
         T_CAN:   key = bus.i_msg[215:152];
         T_EXE:   key = bus.i_msg[247:184];
         default: known = 1'b0;
      endcase
   end

   for (genvar g = 0; g < NUM_SYMBOLS; g++) begin : g_match
      assign match[g] = sym_vld[g] && (sym_key[g] == key);
   end

   // lowest matching table index wins
   always_comb begin
      hit     = |match;
      hit_idx = '0;
      for (int i = NUM_SYMBOLS - 1; i >= 0; i--)
         if (match[i]) hit_idx = SYM_W'(i);
   end

   // assemble the decoded order; fields absent from a message type stay zero
   always_comb begin
      push_ord           = '0;
      push_ord.symbol    = hit_idx;
      push_ord.order_id  = bus.i_msg[151:88];
      push_ord.curr_time = bus.i_msg[87:40];
      push_ord.locate    = bus.i_msg[23:8];
      push_ord.tracking  = bus.i_msg[39:24];
      case (type_b)
         T_ADD: begin
            push_ord.order_type = 2'd0;
            push_ord.trade_type = |bus.i_msg[159:152];
            push_ord.quantity   = bus.i_msg[191:160];
            push_ord.price      = bus.i_msg[287:256];
         end
         T_CAN:   push_ord.order_type = 2'd1;
         T_EXE: begin
            push_ord.order_type = 2'd2;
            push_ord.quantity   = bus.i_msg[183:152];
         end
         default: push_ord.order_type = 2'd0;
      endcase
   end

   assign full        = (count == CNT_FULL);
   assign bus.o_ready = rdy_en && !full;
   assign bus.o_valid = (count != '0);
   assign accept      = bus.i_data_valid && bus.o_ready;
   assign push        = accept && known && hit;
   assign pop         = bus.o_valid && bus.i_book_ready;

   // symbol table: writes land after this edge's lookup has used the old contents
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sym_vld <= '0;
         for (int i = 0; i < NUM_SYMBOLS; i++) sym_key[i] <= '0;
      end else if (bus.i_sym_wr_en && (int'(bus.i_sym_wr_idx) < NUM_SYMBOLS)) begin
         sym_key[bus.i_sym_wr_idx] <= bus.i_sym_wr_key;
         sym_vld[bus.i_sym_wr_idx] <= 1'b1;
      end
   end

   // FIFO storage, pointers and occupancy; rdy_en keeps o_ready low until the first edge out of reset
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdy_en <= 1'b0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (push) begin
            mem[wr_ptr] <= push_ord;
            wr_ptr      <= wr_ptr + PTR_ONE;
         end
         if (pop) rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   count <= count + CNT_ONE;
            2'b01:   count <= count - CNT_ONE;
            default: count <= count;
         endcase
      end
   end

   // saturating drop counters
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         err_type_cnt <= '0;
         err_sym_cnt  <= '0;
      end else begin
         if (accept && !known && (err_type_cnt != '1)) err_type_cnt <= err_type_cnt + ERR_ONE;
         if (accept && known && !hit && (err_sym_cnt != '1)) err_sym_cnt <= err_sym_cnt + ERR_ONE;
      end
   end

   assign head                  = mem[rd_ptr];
   assign bus.o_order_type      = head.order_type;
   assign bus.o_trade_type      = head.trade_type;
   assign bus.o_stock_symbol    = head.symbol;
   assign bus.o_order_id        = head.order_id;
   assign bus.o_price           = head.price;
   assign bus.o_quantity        = head.quantity;
   assign bus.o_curr_time       = head.curr_time;
   assign bus.o_locate_code     = head.locate;
   assign bus.o_tracking_number = head.tracking;
   assign bus.o_err_type_cnt    = err_type_cnt;
   assign bus.o_err_sym_cnt     = err_sym_cnt;
endmodule

// File: tb/tb_order_parser_fifo.sv
// Bench for order_parser_fifo: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_order_parser_fifo;
   localparam int RW = 32, NS = 4, FD = 4, CW = 16, SW = 2;
   localparam logic [63:0] KEY_A = 64'h4141504C20202020;
   localparam logic [63:0] KEY_M = 64'h414D5A4E20202020;

   typedef struct packed {
      logic [1:0]    ot;
      logic          tt;
      logic [SW-1:0] sym;
      logic [63:0]   id;
      logic [31:0]   price;
      logic [31:0]   qty;
      logic [47:0]   tm;
      logic [15:0]   loc;
      logic [15:0]   trk;
   } ord_t;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b1;
   int   checks  = 0;
   int   errors  = 0;

   always #5 i_clk = ~i_clk;

   order_parser_fifo_if #(.REG_WIDTH(RW), .NUM_SYMBOLS(NS), .CNT_W(CW)) bus ();

   order_parser_fifo #(.REG_WIDTH(RW), .NUM_SYMBOLS(NS), .FIFO_DEPTH(FD), .CNT_W(CW)) dut (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .bus    (bus.slave)
   );

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // ---------------- message builders ----------------
   function automatic logic [287:0] common(input logic [7:0] t, input logic [63:0] id);
      logic [287:0] m;
      m          = '0;
      m[7:0]     = t;
      m[23:8]    = id[15:0] ^ 16'hA5A5;
      m[39:24]   = id[15:0] + 16'd3;
      m[87:40]   = {16'hBEEF, id[31:0]};
      m[151:88]  = id;
      return m;
   endfunction

   function automatic logic [287:0] mk_add(input logic [7:0] side, input logic [31:0] qty,
                                           input logic [63:0] key, input logic [31:0] price,
                                           input logic [63:0] id);
      logic [287:0] m;
      m          = common(8'h41, id);
      m[159:152] = side;
      m[191:160] = qty;
      m[255:192] = key;
      m[287:256] = price;
      return m;
   endfunction

   function automatic logic [287:0] mk_cancel(input logic [63:0] key, input logic [63:0] id);
      logic [287:0] m;
      m          = common(8'h58, id);
      m[215:152] = key;
      m[287:216] = '1;   // junk beyond the CANCEL layout must not leak out
      return m;
   endfunction

   function automatic logic [287:0] mk_exec(input logic [31:0] qty, input logic [63:0] key,
                                            input logic [63:0] id);
      logic [287:0] m;
      m          = common(8'h45, id);
      m[183:152] = qty;
      m[247:184] = key;
      m[287:248] = '1;
      return m;
   endfunction

   // ---------------- reference model ----------------
   ord_t        q[$];
   int unsigned m_et = 0, m_es = 0;
   bit          m_rdy = 1'b0;
   logic [63:0] m_key [NS];
   bit          m_v   [NS];

   function automatic bit m_ready();
      return m_rdy && (q.size() < FD);
   endfunction

   function automatic bit decode(input logic [287:0] m, output ord_t o, output logic [63:0] k);
      o     = '0;
      k     = '0;
      o.id  = m[151:88];
      o.tm  = m[87:40];
      o.loc = m[23:8];
      o.trk = m[39:24];
      case (m[7:0])
         8'h41: begin o.ot = 2'd0; o.tt = (m[159:152] != 0); o.qty = m[191:160];
                      k = m[255:192]; o.price = m[287:256]; end
         8'h58: begin o.ot = 2'd1; k = m[215:152]; end
         8'h45: begin o.ot = 2'd2; o.qty = m[183:152]; k = m[247:184]; end
         default: return 1'b0;
      endcase
      return 1'b1;
   endfunction

   always @(posedge i_clk or negedge i_rst_n) begin : model
      bit acc, pop, found;
      ord_t o;
      logic [63:0] k;
      if (!i_rst_n) begin
         q.delete();
         m_et  = 0;
         m_es  = 0;
         m_rdy = 1'b0;
         for (int i = 0; i < NS; i++) m_v[i] = 1'b0;
      end else begin
         acc = bus.i_data_valid && m_ready();
         pop = (q.size() > 0) && bus.i_book_ready;
         if (pop) void'(q.pop_front());
         if (acc) begin
            if (!decode(bus.i_msg, o, k)) begin
               if (m_et < (1 << CW) - 1) m_et++;
            end else begin
               found = 1'b0;
               for (int i = 0; i < NS; i++)
                  if (!found && m_v[i] && m_key[i] == k) begin
                     found = 1'b1;
                     o.sym = SW'(i);
                  end
               if (found) q.push_back(o);
               else if (m_es < (1 << CW) - 1) m_es++;
            end
         end
         if (bus.i_sym_wr_en) begin
            m_key[bus.i_sym_wr_idx] = bus.i_sym_wr_key;
            m_v[bus.i_sym_wr_idx]   = 1'b1;
         end
         m_rdy = 1'b1;
      end
   end

   // ---------------- per-cycle comparison ----------------
   ord_t act;
   assign act = {bus.o_order_type, bus.o_trade_type, bus.o_stock_symbol, bus.o_order_id,
                 bus.o_price, bus.o_quantity, bus.o_curr_time, bus.o_locate_code,
                 bus.o_tracking_number};

   always @(negedge i_clk) begin
      chk("o_valid", bus.o_valid, q.size() != 0);
      chk("o_ready", bus.o_ready, m_ready());
      chk("err_type_cnt", bus.o_err_type_cnt, m_et);
      chk("err_sym_cnt", bus.o_err_sym_cnt, m_es);
      if (q.size() != 0) chk("head", act, q[0]);
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(input logic [287:0] m);
      int   n = 0;
      logic ok;
      bus.i_msg        = m;
      bus.i_data_valid = 1'b1;
      do begin
         @(negedge i_clk);
         ok = bus.o_ready;
         tick();
         n++;
      end while (!ok && n < 50);
      if (!ok) chk("send_timeout", 1'b0, 1'b1);
      bus.i_data_valid = 1'b0;
   endtask

   int pops;

   initial begin
      bus.i_data_valid = 1'b0;
      bus.i_msg        = '0;
      bus.i_sym_wr_en  = 1'b0;
      bus.i_sym_wr_idx = '0;
      bus.i_sym_wr_key = '0;
      bus.i_book_ready = 1'b0;
      #1 i_rst_n = 1'b0;

      // reset state
      repeat (3) tick();
      chk("rst_o_ready", bus.o_ready, 1'b0);
      chk("rst_o_valid", bus.o_valid, 1'b0);
      chk("rst_err_type", bus.o_err_type_cnt, 0);
      chk("rst_order_id", bus.o_order_id, 0);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("rdy_before_edge", bus.o_ready, 1'b0);
      tick();
      chk("rdy_after_edge", bus.o_ready, 1'b1);

      // basic ADD
      bus.i_sym_wr_en = 1'b1; bus.i_sym_wr_idx = 2'd0; bus.i_sym_wr_key = KEY_A;
      tick();
      bus.i_sym_wr_en = 1'b0;
      send(mk_add(8'd1, 32'd100, KEY_A, 32'd1500, 64'd7));
      chk("add_valid", bus.o_valid, 1'b1);
      chk("add_type", bus.o_order_type, 2'd0);
      chk("add_side", bus.o_trade_type, 1'b1);
      chk("add_sym", bus.o_stock_symbol, 2'd0);
      chk("add_qty", bus.o_quantity, 32'd100);
      chk("add_price", bus.o_price, 32'd1500);
      chk("add_id", bus.o_order_id, 64'd7);
      bus.i_book_ready = 1'b1;
      tick();
      bus.i_book_ready = 1'b0;
      chk("add_popped", bus.o_valid, 1'b0);

      // fill to full, fifth order held on the bus
      for (int i = 1; i <= 4; i++) send(mk_add(8'd0, 32'(10 * i), KEY_A, 32'(1000 + i), 64'(i)));
      chk("full_rdy", bus.o_ready, 1'b0);
      bus.i_msg = mk_add(8'd0, 32'd50, KEY_A, 32'd1005, 64'd5);
      bus.i_data_valid = 1'b1;
      repeat (3) tick();
      chk("full_hold_rdy", bus.o_ready, 1'b0);
      chk("full_hold_head", bus.o_order_id, 64'd1);
      bus.i_book_ready = 1'b1;
      tick();
      bus.i_book_ready = 1'b0;
      chk("pop_frees_rdy", bus.o_ready, 1'b1);
      chk("pop_head2", bus.o_order_id, 64'd2);
      tick();
      bus.i_data_valid = 1'b0;
      bus.i_book_ready = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         @(negedge i_clk);
         chk("drain_id", bus.o_order_id, 64'(i));
         chk("drain_side", bus.o_trade_type, 1'b0);
         tick();
      end
      bus.i_book_ready = 1'b0;
      chk("drained", bus.o_valid, 1'b0);

      // unknown type and saturation
      send(common(8'h51, 64'd9));
      chk("unk_cnt1", bus.o_err_type_cnt, 16'd1);
      chk("unk_no_push", bus.o_valid, 1'b0);
      bus.i_data_valid = 1'b1;
      repeat ((1 << CW) + 3) @(posedge i_clk);
      #1 bus.i_data_valid = 1'b0;
      chk("unk_sat", bus.o_err_type_cnt, 16'hFFFF);

      // symbol miss, same-cycle write, then hit
      i_rst_n = 1'b0;
      tick();
      i_rst_n = 1'b1;
      tick();
      send(mk_cancel(KEY_M, 64'd20));
      chk("miss_cnt1", bus.o_err_sym_cnt, 16'd1);
      chk("miss_no_push", bus.o_valid, 1'b0);
      bus.i_sym_wr_en = 1'b1; bus.i_sym_wr_idx = 2'd1; bus.i_sym_wr_key = KEY_M;
      send(mk_cancel(KEY_M, 64'd21));
      bus.i_sym_wr_en = 1'b0;
      chk("wr_same_cycle_cnt", bus.o_err_sym_cnt, 16'd2);
      chk("wr_same_cycle_drop", bus.o_valid, 1'b0);
      send(mk_cancel(KEY_M, 64'd22));
      send(mk_exec(32'd77, KEY_M, 64'd23));
      chk("can_type", bus.o_order_type, 2'd1);
      chk("can_sym", bus.o_stock_symbol, 2'd1);
      chk("can_price", bus.o_price, 32'd0);
      chk("can_qty", bus.o_quantity, 32'd0);
      chk("can_id", bus.o_order_id, 64'd22);
      bus.i_book_ready = 1'b1;
      tick();
      chk("exe_type", bus.o_order_type, 2'd2);
      chk("exe_qty", bus.o_quantity, 32'd77);
      chk("exe_price", bus.o_price, 32'd0);
      tick();

      // streaming, one order per cycle
      pops = 0;
      bus.i_data_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         bus.i_msg = mk_exec(32'(i + 1), KEY_M, 64'(100 + i));
         @(negedge i_clk);
         chk("stream_rdy", bus.o_ready, 1'b1);
         if (bus.o_valid) pops++;
         tick();
      end
      bus.i_data_valid = 1'b0;
      @(negedge i_clk);
      if (bus.o_valid) pops++;
      tick();
      bus.i_book_ready = 1'b0;
      chk("stream_pops", pops, 20);
      chk("stream_empty", bus.o_valid, 1'b0);

      // reset mid-operation
      for (int i = 0; i < 3; i++) send(mk_exec(32'd5, KEY_M, 64'(200 + i)));
      #2 i_rst_n = 1'b0;
      #1;
      chk("midrst_valid", bus.o_valid, 1'b0);
      chk("midrst_rdy", bus.o_ready, 1'b0);
      chk("midrst_err_sym", bus.o_err_sym_cnt, 16'd0);
      chk("midrst_id", bus.o_order_id, 64'd0);
      tick();
      i_rst_n = 1'b1;
      tick();
      send(mk_cancel(KEY_M, 64'd300));
      chk("table_cleared", bus.o_err_sym_cnt, 16'd1);
      chk("table_cleared_drop", bus.o_valid, 1'b0);

      repeat (2) tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
